nrzi_rx_front: RTL and testbench
================================

# nrzi_rx_front

USB full-speed receive front end: samples the serial D+ line, flags every line transition, and recovers the original bit stream from NRZI encoding.
- Sits between the bus pins and the receive controller.
- The controller uses `d_edge` to resynchronise its bit timer.
- It pulses `shift_enable` once per bit period and consumes `d_orig` into its shift register.
- It asserts `eop` when it detects end-of-packet.

## Interface
Parameters:
- `IDLE_LVL`, default 1'b1: D+ idle (J) level; reset value of all sampling flops.

Ports:
- `clk` input 1: single system clock; all flops on rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `d_plus` input 1: raw serial D+ line, asynchronous to `clk`.
- `shift_enable` input 1: one-cycle strobe at the bit-sample point.
- `eop` input 1: end-of-packet indication from the controller, qualified by `shift_enable`.
- `d_edge` output 1: one-cycle pulse on any transition of the sampled D+.
- `d_orig` output 1: NRZI-decoded bit; 1 means no transition versus the previous sampled bit.

## Operation
- **`cur` flop:** sampled D+, loaded from the (optionally synchronised) `d_plus` every cycle.
- **`prev` flop:** `cur` delayed by one cycle.
- **Edge output:** `d_edge = cur ^ prev`, combinational.
- **`last_bit` flop:** previous bit-period level. Load rules:
  - `shift_enable` && `eop`: load `IDLE_LVL`. This prepares the idle reference for the next packet.
  - `shift_enable` && !`eop`: load `cur`.
  - Otherwise: hold.
- **Decoded output:** `d_orig = ~(cur ^ last_bit)`, combinational.
- **Decode rule:** a line transition between bit samples decodes to 0; no transition decodes to 1.
- **Transition cases for `d_edge`:** falling and rising transitions both pulse `d_edge`. A one-cycle glitch on `cur` produces two consecutive pulses.
- **`shift_enable` and `eop`:** no handshake. `eop` is ignored unless `shift_enable` is high.

## Timing
- **Reset:** `cur`, `prev`, `last_bit` and the synchroniser flops all reset to `IDLE_LVL`. Hence `d_edge`=0 and `d_orig`=1 out of reset.
- **Latency of `cur`, from a `d_plus` change:**
  - With the synchroniser: `cur` changes on the 2nd rising edge.
  - Without it: `cur` changes on the 1st rising edge.
- **`d_edge` timing:** asserts in the cycle `cur` changes. It is high for exactly one cycle, provided D+ is stable for ≥2 cycles.
- **`d_orig` validity:** valid combinationally in the same cycle as `shift_enable`. `last_bit` updates at the end of that cycle.
- **Reset mid-packet:** the decoder returns to the idle reference immediately, asynchronously. The first bit after reset compares against `IDLE_LVL`.
- **D+ change in the same cycle as `shift_enable`:** `d_orig` uses the pre-edge `cur`, i.e. the value already registered.

## Configuration
- **Macro:** `NRZI_RX_SYNC_EN`.
- **Defined:** `d_plus` passes through a 2-flop metastability synchroniser, reset to `IDLE_LVL`, before `cur`. Input-to-`cur` latency is 2 cycles.
- **Undefined:** `d_plus` feeds `cur` directly. Latency is 1 cycle, for benches driving a synchronous stimulus.
- **Unaffected:** `d_edge` and `d_orig` behaviour relative to `cur` is identical in both builds.

## Structure
- **Shared package `usb_rx_pkg`:** holds `IDLE_LVL` default (`USB_J_LVL` = 1'b1) and the `USB_SYNC_STAGES` = 2 constant.
- **Sub-module `edge_det`:** owns `cur`/`prev` and the optional synchroniser, and outputs `cur` and `d_edge`.
- **Top:** contains `last_bit` and the decode logic.

## Test plan
1. **Reset state:** hold `n_rst`=0 with `d_plus`=1 for 2 cycles, then release. Required: `d_edge`=0, `d_orig`=1, and no pulse for 3 idle cycles.
2. **Falling edge:** `d_plus` 1→0, held 8 cycles. Required:
   - exactly one `d_edge` pulse, 1 or 2 cycles after the change, per the macro;
   - `shift_enable` strobe at cycle 4 gives `d_orig`=0.
3. **Rising edge after 16-cycle stable low:** `d_plus` 0→1. Required:
   - one `d_edge` pulse;
   - a strobe before the change gives `d_orig`=1;
   - a strobe after the change gives `d_orig`=0.
4. **Bit sequence:** bit period 8 cycles, strobe mid-bit, line levels 0,0,1,0,1,1,1,1. Required: decoded `d_orig` 0,1,0,0,0,1,1,1.
5. **EOP:** `shift_enable`=`eop`=1 while `cur`=0, then the line goes to 1. Required: next strobe gives `d_orig`=1, because the reference is forced to J.
6. **Async reset mid-packet:** pulse `n_rst` low between clock edges while `cur`=0. Required: `d_edge`=0 and `d_orig`=1 immediately; the first post-reset 1→0 edge pulses once.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared USB receive constants: J-state idle level, synchroniser depth, NRZI decode helper.
// Pure declarations, no latency or flow control of its own.
package usb_rx_pkg;

  localparam logic USB_J_LVL       = 1'b1;
  localparam int   USB_SYNC_STAGES = 2;

  // NRZI: no change versus the reference level decodes to 1, a change decodes to 0.
  function automatic logic nrzi_bit(input logic cur_lvl, input logic ref_lvl);
    return ~(cur_lvl ^ ref_lvl);
  endfunction

endpackage

// File: rtl/nrzi_rx_front_if.sv
// Line-side bundle of the NRZI receive front end: raw D+, bit strobe/EOP in, edge/decoded bit out.
// No handshake: shift_enable is a one-cycle strobe and eop is only meaningful alongside it.
interface nrzi_rx_front_if;

  logic d_plus;
  logic shift_enable;
  logic eop;
  logic d_edge;
  logic d_orig;

  modport master (
    output d_plus,
    output shift_enable,
    output eop,
    input  d_edge,
    input  d_orig
  );

  modport slave (
    input  d_plus,
    input  shift_enable,
    input  eop,
    output d_edge,
    output d_orig
  );

endinterface

// File: rtl/edge_det.sv
// Samples D+ into cur/prev and flags every transition; d_plus-to-cur is 2 cycles with NRZI_RX_SYNC_EN, else 1.
// No backpressure: samples every cycle, d_edge is combinational from cur/prev.
module edge_det
  import usb_rx_pkg::*;
#(
  parameter logic IDLE_LVL = USB_J_LVL
)
(
  input  logic clk,
  input  logic n_rst,
  input  logic i_d_plus,
  output logic o_cur,
  output logic o_d_edge
);

  logic w_d_in;
  logic r_cur;
  logic r_prev;

`ifdef NRZI_RX_SYNC_EN
  // cur is the last stage of the synchroniser, so only the stages ahead of it live here.
  localparam int PRE_STAGES = USB_SYNC_STAGES - 1;

  logic [PRE_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync <= {PRE_STAGES{IDLE_LVL}};
    end else begin
      r_sync[0] <= i_d_plus;
      for (int i = 1; i < PRE_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_d_in = r_sync[PRE_STAGES-1];
`else
  assign w_d_in = i_d_plus;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cur  <= IDLE_LVL;
      r_prev <= IDLE_LVL;
    end else begin
      r_cur  <= w_d_in;
      r_prev <= r_cur;
    end
  end

  assign o_cur    = r_cur;
  assign o_d_edge = r_cur ^ r_prev;

endmodule

// File: rtl/nrzi_rx_front.sv
// USB FS receive front end: edge flag + NRZI decode against last bit-period level (optional sync: NRZI_RX_SYNC_EN).
// d_orig valid combinationally in the shift_enable cycle; no backpressure, strobe-driven only.
module nrzi_rx_front
  import usb_rx_pkg::*;
#(
  parameter logic IDLE_LVL = USB_J_LVL
)
(
  input  logic             clk,
  input  logic             n_rst,
  nrzi_rx_front_if.slave   bus
);

  logic w_cur;
  logic w_d_edge;
  logic r_last_bit;

  edge_det #(
    .IDLE_LVL (IDLE_LVL)
  ) u_edge_det (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_d_plus (bus.d_plus),
    .o_cur    (w_cur),
    .o_d_edge (w_d_edge)
  );

  // At EOP the reference snaps back to J so the next packet's first bit decodes against idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_last_bit <= IDLE_LVL;
    end else if (bus.shift_enable) begin
      r_last_bit <= bus.eop ? IDLE_LVL : w_cur;
    end
  end

  assign bus.d_edge = w_d_edge;
  assign bus.d_orig = nrzi_bit(w_cur, r_last_bit);

endmodule

// File: tb/tb_nrzi_rx_front.sv
// Scoreboard bench for nrzi_rx_front: expected edge cycles and decoded bits queued at drive time, popped at negedge.
module tb_nrzi_rx_front;
  import usb_rx_pkg::*;

`ifdef NRZI_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_q[$];
  logic orig_q[$];
  logic last_dp;

  bit lvls [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  bit exps [0:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  nrzi_rx_front_if bus ();

  nrzi_rx_front #(
    .IDLE_LVL (USB_J_LVL)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of stimulus; a d_plus change shows up on d_edge LAT cycles later.
  task automatic step(input logic dp, input logic se, input logic ep, input logic exp_orig);
    @(posedge clk);
    #1;
    bus.d_plus       = dp;
    bus.shift_enable = se;
    bus.eop          = ep;
    if (dp !== last_dp) edge_q.push_back(cyc + LAT);
    last_dp = dp;
    if (se) orig_q.push_back(exp_orig);
  endtask

  task automatic idle(input int n, input logic dp);
    repeat (n) step(dp, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic strobe(input logic dp, input logic exp_orig);
    step(dp, 1'b1, 1'b0, exp_orig);
  endtask

  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      while (edge_q.size() != 0 && edge_q[0] < cyc) begin
        check_eq("edge_missed", cyc, edge_q[0]);
        void'(edge_q.pop_front());
      end
      if (bus.d_edge !== 1'b0) begin
        if (edge_q.size() != 0 && edge_q[0] == cyc)
          check_eq("edge_pulse", cyc, edge_q.pop_front());
        else
          check_eq("edge_spurious", 32'(bus.d_edge), 0);
      end
      if (bus.shift_enable === 1'b1 && orig_q.size() != 0)
        check_eq("d_orig", 32'(bus.d_orig), 32'(orig_q.pop_front()));
    end
  end

  initial begin
    n_rst            = 1'b0;
    bus.d_plus       = 1'b1;
    bus.shift_enable = 1'b0;
    bus.eop          = 1'b0;
    last_dp          = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_edge", 32'(bus.d_edge), 0);
    check_eq("rst_orig", 32'(bus.d_orig), 1);
    n_rst = 1'b1;
    idle(3, 1'b1);
    check_eq("idle_edge", 32'(bus.d_edge), 0);
    check_eq("idle_orig", 32'(bus.d_orig), 1);

    // Falling edge, strobe at cycle 4 of an 8-cycle low
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    strobe(1'b0, 1'b0);
    idle(3, 1'b0);
    check_eq("fall_edges_left", edge_q.size(), 0);

    // Rising edge after 16 cycles low
    idle(4, 1'b0);
    strobe(1'b0, 1'b1);
    idle(3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);
    strobe(1'b1, 1'b0);
    idle(3, 1'b1);
    check_eq("rise_edges_left", edge_q.size(), 0);

    // Bit sequence, 8-cycle bit period, strobe mid-bit
    for (int b = 0; b < 8; b++) begin
      idle(4, lvls[b]);
      strobe(lvls[b], exps[b]);
      idle(3, lvls[b]);
    end

    // EOP forces the reference back to J
    idle(4, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);
    strobe(1'b1, 1'b1);
    idle(3, 1'b1);

    // eop without shift_enable must not touch the reference
    idle(4, 1'b0);
    strobe(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    strobe(1'b1, 1'b0);
    idle(3, 1'b1);

    // Line change in the strobe cycle decodes the already-registered level
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b0);
    strobe(1'b0, 1'b0);
    idle(3, 1'b0);

    // One-cycle glitch gives two back-to-back pulses
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    check_eq("glitch_edges_left", edge_q.size(), 0);

    // Async reset mid-packet with cur=0 and reference=1
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);
    strobe(1'b1, 1'b0);
    idle(3, 1'b1);
    idle(5, 1'b0);
    check_eq("pre_arst_orig", 32'(bus.d_orig), 0);
    #1;
    n_rst = 1'b0;
    #1;
    check_eq("arst_edge", 32'(bus.d_edge), 0);
    check_eq("arst_orig", 32'(bus.d_orig), 1);
    #1;
    n_rst = 1'b1;
    // Flops restart at J while the line is still low, so one falling edge follows.
    edge_q.push_back(cyc + LAT);
    idle(3, 1'b0);
    strobe(1'b0, 1'b0);
    idle(4, 1'b0);

    check_eq("edge_q_empty", edge_q.size(), 0);
    check_eq("orig_q_empty", orig_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
